phase_tx: RTL and testbench

- Transmit end of the phased 4-bit capture interface. Generates the free-running 3-bit phase count `clk_out` and drives the 4-bit data word `a0` that the downstream capture stage samples at phases 4 and 6.
- Buffers words from an upstream producer in a small FIFO with a valid/ready handshake.
- Presents exactly one word per 8-phase frame, held stable for the whole frame.

---
 rtl/phase_tx.sv | 126 ++++++++++++
 tb/tb_phase_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_tx.sv
// ---------------------------------------------------------------------------
// phase_tx
//
// Purpose:
//   This is the transmit end of the phased 4-bit capture interface. A
//   free-running 3-bit phase count (clk_out) splits time into 8-phase frames.
//   Words from an upstream producer are buffered in a small FIFO that uses a
//   valid/ready handshake. At each frame boundary, which is the enabled cycle
//   with clk_out == 7, one word is popped onto a0. That word then stays
//   stable for the whole next frame, so the capture stage can sample it at
//   phases 4 and 6.
//
// Parameters:
//   DEPTH      number of FIFO entries (a power of 2, at least 2)
//   AW         FIFO pointer width, log2(DEPTH)
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous, active-high reset; overrides every other event
//   enable     1 = phase counter advances; 0 = everything frozen except push
//   in_valid   upstream word available
//   in_data    upstream word
//   in_ready   FIFO can accept a word (derived from registered count only)
//   clk_out    phase count 0..7 for the capture stage
//   a0         word presented to the capture stage
//   a0_valid   1 = a0 holds a word popped at the last frame boundary
//   fifo_count number of buffered words (AW+1 bits so DEPTH fits)
//   sent_count words presented since reset, wraps 255 -> 0
// ---------------------------------------------------------------------------
module phase_tx #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [3:0]    in_data,
  output logic          in_ready,
  output logic [2:0]    clk_out,
  output logic [3:0]    a0,
  output logic          a0_valid,
  output logic [AW:0]   fifo_count,
  output logic [7:0]    sent_count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [2:0]  LAST_PHASE = 3'd7;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          boundary;
  logic          push;
  logic          pop;

  // in_ready looks only at the registered count. A pop in the same cycle
  // therefore does not open the FIFO until the following cycle.
  assign in_ready = (fifo_count != FULL_COUNT);
  assign push     = in_valid && in_ready;

  // The frame boundary is the only moment a word may leave the FIFO.
  assign boundary = enable && (clk_out == LAST_PHASE);

  // The pop decision uses the count from before this edge. A word pushed
  // into an empty FIFO at a boundary is therefore held for a full frame, so
  // there is no bypass path.
  assign pop      = boundary && (fifo_count != '0);

  // The storage array needs no reset. The pointers and count decide which
  // entries are meaningful, so a reset discards all buffered words.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap on their own because
  // DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Free-running phase counter. It wraps 7 -> 0 by its natural width.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out <= '0;
    end else if (enable) begin
      clk_out <= clk_out + 3'd1;
    end
  end

  // Presentation register. a0 changes only at a boundary with data
  // available. An empty boundary clears a0_valid but leaves the old word on
  // a0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a0         <= '0;
      a0_valid   <= 1'b0;
      sent_count <= '0;
    end else if (pop) begin
      a0         <= mem[rd_ptr];
      a0_valid   <= 1'b1;
      sent_count <= sent_count + 8'd1;
    end else if (boundary) begin
      a0_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phase_tx.sv
// ---------------------------------------------------------------------------
// tb_phase_tx
//
// Directed bench for phase_tx. The stimulus thread pushes each word it
// expects to be presented into exp_q. The monitor watches sent_count, and
// every time it advances the monitor pops exp_q and checks the word shown on
// a0. The stimulus thread also makes directed checks of phase, occupancy and
// flag values, all hand-computed.
// ---------------------------------------------------------------------------
module tb_phase_tx;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [2:0] clk_out;
  logic [3:0] a0;
  logic       a0_valid;
  logic [2:0] fifo_count;
  logic [7:0] sent_count;

  int         checks;
  int         errors;
  logic [3:0] exp_q[$];
  logic       rst_at_edge;
  logic [7:0] prev_sent;

  phase_tx #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .clk_out    (clk_out),
    .a0         (a0),
    .a0_valid   (a0_valid),
    .fifo_count (fifo_count),
    .sent_count (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog, so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one handshake cycle. If the caller knows by hand that the word
  // will be presented later, it queues the word as expected output.
  task automatic applyStimulus(input logic valid, input logic [3:0] data,
                               input logic expect_presented);
    in_valid = valid;
    in_data  = data;
    if (expect_presented) exp_q.push_back(data);
    @(negedge clk);
  endtask

  task automatic waitPhase(input logic [2:0] p);
    int n;
    n = 0;
    while (clk_out !== p && n < 16) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (clk_out !== p) begin
      errors++;
      $display("[TB] FAIL wait_phase: got %0d, expected %0d within 16 cycles", clk_out, p);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_clk_out"},    8'(clk_out),    8'd0);
    checkOutput({tag, "_a0"},         8'(a0),         8'd0);
    checkOutput({tag, "_a0_valid"},   8'(a0_valid),   8'd0);
    checkOutput({tag, "_fifo_count"}, 8'(fifo_count), 8'd0);
    checkOutput({tag, "_sent_count"}, sent_count,     8'd0);
    checkOutput({tag, "_in_ready"},   8'(in_ready),   8'd1);
  endtask

  // Monitor. Every advance of sent_count is a presented word, and it must
  // match the head of the scoreboard.
  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (rst_at_edge === 1'b1) begin
      prev_sent = 8'd0;
    end else if (rst_at_edge === 1'b0 && sent_count !== prev_sent) begin
      checkOutput("mon_sent_step", sent_count, 8'(prev_sent + 8'd1));
      checkOutput("mon_phase_at_pop", 8'(clk_out), 8'd0);
      checkOutput("mon_a0_valid_at_pop", 8'(a0_valid), 8'd1);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL mon_unexpected_word: got %0h, expected no word", a0);
      end else begin
        logic [3:0] exp_word;
        exp_word = exp_q.pop_front();
        if (a0 !== exp_word) begin
          errors++;
          $display("[TB] FAIL mon_a0_word: got %0h, expected %0h", a0, exp_word);
        end
      end
      prev_sent = sent_count;
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    prev_sent = 8'd0;
    repeat (2) @(negedge clk);
    checkReset("rst0");

    // Free run with no input. The phase counts 1..7,0,... and nothing is
    // ever presented.
    rst    = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checkOutput("run_clk_out", 8'(clk_out), 8'(i % 8));
      checkOutput("run_a0_valid", 8'(a0_valid), 8'd0);
      checkOutput("run_a0", 8'(a0), 8'd0);
      checkOutput("run_sent", sent_count, 8'd0);
      checkOutput("run_in_ready", 8'(in_ready), 8'd1);
    end

    // Single word pushed at phase 1. It appears at the phase-7 boundary.
    waitPhase(3'd1);
    applyStimulus(1'b1, 4'hA, 1'b1);
    in_valid = 1'b0;
    checkOutput("one_count", 8'(fifo_count), 8'd1);
    repeat (5) @(negedge clk);
    checkOutput("one_phase7", 8'(clk_out), 8'd7);
    checkOutput("one_not_yet", 8'(a0_valid), 8'd0);
    @(negedge clk);
    checkOutput("one_a0", 8'(a0), 8'hA);
    checkOutput("one_valid", 8'(a0_valid), 8'd1);
    checkOutput("one_count0", 8'(fifo_count), 8'd0);
    checkOutput("one_sent", sent_count, 8'd1);
    repeat (4) @(negedge clk);
    checkOutput("one_ph4_phase", 8'(clk_out), 8'd4);
    checkOutput("one_ph4_a0", 8'(a0), 8'hA);
    repeat (2) @(negedge clk);
    checkOutput("one_ph6_a0", 8'(a0), 8'hA);
    repeat (2) @(negedge clk);
    checkOutput("one_next_valid", 8'(a0_valid), 8'd0);
    checkOutput("one_next_a0", 8'(a0), 8'hA);
    checkOutput("one_next_sent", sent_count, 8'd1);

    // Fill the FIFO back to back, then hold a fifth word until there is room.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 1'b1);
    checkOutput("full_count", 8'(fifo_count), 8'd4);
    checkOutput("full_ready", 8'(in_ready), 8'd0);
    in_data = 4'h5;
    exp_q.push_back(4'h5);
    repeat (3) @(negedge clk);
    checkOutput("full_hold_phase", 8'(clk_out), 8'd7);
    checkOutput("full_hold_count", 8'(fifo_count), 8'd4);
    checkOutput("full_hold_ready", 8'(in_ready), 8'd0);
    @(negedge clk);
    checkOutput("full_pop_count", 8'(fifo_count), 8'd3);
    checkOutput("full_pop_ready", 8'(in_ready), 8'd1);
    checkOutput("full_pop_a0", 8'(a0), 8'h1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("full_take5_count", 8'(fifo_count), 8'd4);
    checkOutput("full_take5_ready", 8'(in_ready), 8'd0);
    repeat (31) @(negedge clk);
    checkOutput("drain_a0", 8'(a0), 8'h5);
    checkOutput("drain_sent", sent_count, 8'd6);
    checkOutput("drain_count", 8'(fifo_count), 8'd0);
    repeat (8) @(negedge clk);
    checkOutput("drain_idle_valid", 8'(a0_valid), 8'd0);
    checkOutput("drain_idle_a0", 8'(a0), 8'h5);

    // A push at the boundary into an empty FIFO waits one full frame.
    waitPhase(3'd7);
    applyStimulus(1'b1, 4'h7, 1'b1);
    in_valid = 1'b0;
    checkOutput("nobypass_valid", 8'(a0_valid), 8'd0);
    checkOutput("nobypass_a0", 8'(a0), 8'h5);
    checkOutput("nobypass_count", 8'(fifo_count), 8'd1);
    repeat (8) @(negedge clk);
    checkOutput("late_a0", 8'(a0), 8'h7);
    checkOutput("late_valid", 8'(a0_valid), 8'd1);
    checkOutput("late_sent", sent_count, 8'd7);

    // Freeze the phase while still accepting a push.
    waitPhase(3'd5);
    enable = 1'b0;
    applyStimulus(1'b1, 4'hC, 1'b1);
    in_valid = 1'b0;
    checkOutput("frz_push_count", 8'(fifo_count), 8'd1);
    repeat (4) @(negedge clk);
    checkOutput("frz_phase", 8'(clk_out), 8'd5);
    checkOutput("frz_a0", 8'(a0), 8'h7);
    checkOutput("frz_valid", 8'(a0_valid), 8'd1);
    checkOutput("frz_sent", sent_count, 8'd7);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("resume_phase", 8'(clk_out), 8'd6);
    repeat (2) @(negedge clk);
    checkOutput("resume_a0", 8'(a0), 8'hC);
    checkOutput("resume_sent", sent_count, 8'd8);
    checkOutput("resume_count", 8'(fifo_count), 8'd0);

    // Reset mid-frame discards buffered words.
    applyStimulus(1'b1, 4'hD, 1'b0);
    applyStimulus(1'b1, 4'hE, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b0);
    in_valid = 1'b0;
    checkOutput("pre_rst_phase", 8'(clk_out), 8'd3);
    checkOutput("pre_rst_count", 8'(fifo_count), 8'd3);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkReset("rst_mid");
    rst = 1'b0;
    repeat (16) @(negedge clk);
    checkOutput("post_rst_sent", sent_count, 8'd0);
    checkOutput("post_rst_valid", 8'(a0_valid), 8'd0);
    checkOutput("post_rst_a0", 8'(a0), 8'd0);
    checkOutput("post_rst_phase", 8'(clk_out), 8'd0);

    // One word per frame, enough frames to wrap sent_count.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 4'(i), 1'b1);
      in_valid = 1'b0;
      repeat (7) @(negedge clk);
      if (i == 254) checkOutput("wrap_255", sent_count, 8'd255);
    end
    checkOutput("wrap_0", sent_count, 8'd0);
    checkOutput("wrap_a0", 8'(a0), 8'hF);
    checkOutput("wrap_valid", 8'(a0_valid), 8'd1);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
